// File: rtl/params_pkg.sv
// Shared fetch-stage types and constants: widths, instruction word type,
// fetch FSM encoding, NOP and reset PC, plus a saturating counter helper.
package params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] instruction_t;

    // F_REQ: may issue; F_WAIT: one request in flight;
    // F_DRAIN: the in-flight response is wrong-path and gets dropped.
    typedef enum logic [1:0] {
        F_REQ   = 2'd0,
        F_WAIT  = 2'd1,
        F_DRAIN = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam instruction_t NOP_INSTR = 32'h0000_0013;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000;

    // Add a small increment to a 32-bit event counter, sticking at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the fetch PC, issues single-outstanding
// requests to a variable-latency instruction memory, and holds a registered
// {valid, pc, instruction} slot for decode. A redirect flushes the slot and
// turns any in-flight response into a wrong-path one that is dropped.
// Optional build macro: FETCH_PERF_CNT_EN adds fetched / squashed /
// stall-cycle event counters and their output ports.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = params_pkg::RESET_PC
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDR_WIDTH-1:0]    imem_addr_o,
    input  logic                     imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
    output logic                     valid_o,
    output logic [ADDR_WIDTH-1:0]    pc_o,
    output params_pkg::instruction_t instruction_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetched_o,
    output logic [31:0]              perf_squashed_o,
    output logic [31:0]              perf_stall_cycles_o
`endif
);

    import params_pkg::*;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    instruction_t          instr_q, instr_d;

    logic                  imem_req;
    logic                  resp_load;
    logic                  resp_drop;
    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;

    // Instructions are word aligned; the low two target bits carry no meaning.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign redirect_pc_aligned  = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

    // Request only when idle, not being redirected, and the slot can take the result.
    always_comb begin
        imem_req  = (state_q == F_REQ) && !redirect_i && (!valid_q || !stall_i);
        // A response is useful only while waiting on the right path.
        resp_load = (state_q == F_WAIT) && imem_rvalid_i && !redirect_i;
        resp_drop = imem_rvalid_i &&
                    (((state_q == F_WAIT) && redirect_i) || (state_q == F_DRAIN));
    end

    assign imem_req_o  = imem_req;
    assign imem_addr_o = pc_q;

    // FSM next-state plus PC and slot updates; redirect overrides everything.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;

        // Decode takes the slot this edge.
        if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            F_REQ: begin
                if (imem_req) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (resp_load || resp_drop) begin
                    state_d = F_REQ;
                end else if (redirect_i) begin
                    state_d = F_DRAIN;
                end
            end
            F_DRAIN: begin
                if (resp_drop) begin
                    state_d = F_REQ;
                end
            end
            default: begin
                state_d = F_REQ;
            end
        endcase

        if (resp_load) begin
            valid_d  = 1'b1;
            pc_out_d = pc_q;
            instr_d  = instruction_t'(imem_rdata_i);
            pc_d     = pc_q + ADDR_WIDTH'(4);
        end

        // Flush the slot and restart; pc_o / instruction_o may go stale.
        if (redirect_i) begin
            pc_d    = redirect_pc_aligned;
            valid_d = 1'b0;
        end
    end

    // State, PC and slot registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= F_REQ;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            instr_q  <= NOP_INSTR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pc_out_q;
    assign instruction_o = instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q,  perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;
    logic [31:0] perf_stall_q,    perf_stall_d;
    logic [1:0]  squash_inc;

    // A dropped response and a flushed valid slot can coincide; count both.
    always_comb begin
        squash_inc      = {1'b0, resp_drop} + {1'b0, (redirect_i && valid_q)};
        perf_fetched_d  = sat_add32(perf_fetched_q, {1'b0, resp_load});
        perf_squashed_d = sat_add32(perf_squashed_q, squash_inc);
        perf_stall_d    = sat_add32(perf_stall_q, {1'b0, (valid_q && stall_i)});
    end

    // Event counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_fetched_o      = perf_fetched_q;
    assign perf_squashed_o     = perf_squashed_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stall / redirect / latency / reset traffic
// checked every cycle against a transaction-level model with a bench-side
// variable-latency memory.
module tb_fetch_stage;
    import params_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         stall_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         imem_req_o;
    logic [31:0]  imem_addr_o;
    logic         imem_rvalid_i;
    logic [31:0]  imem_rdata_i;
    logic         valid_o;
    logic [31:0]  pc_o;
    instruction_t instruction_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  perf_fetched_o, perf_squashed_o, perf_stall_cycles_o;
`endif

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .instruction_o (instruction_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o      (perf_fetched_o),
        .perf_squashed_o     (perf_squashed_o),
        .perf_stall_cycles_o (perf_stall_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus knobs for the next cycle
    bit          rst_n_v = 1'b0;
    bit          st_v    = 1'b0;
    bit          rd_v    = 1'b0;
    logic [31:0] rpc_v   = '0;
    int          lat_v   = 1;

    // bench memory: one pending request with a countdown
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;

    // transaction-level model
    logic [31:0]  m_pc      = '0;
    bit           m_infl    = 1'b0;
    bit           m_stale   = 1'b0;
    logic [31:0]  m_infl_pc = '0;
    bit           m_sv      = 1'b0;
    logic [31:0]  m_spc     = '0;
    instruction_t m_sins    = '0;
    bit           prev_rst_low = 1'b0;
    longint       m_pf = 0, m_ps = 0, m_pst = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic instruction_t mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_8113;
            default:       return {a[7:0], a[31:8]} ^ 32'h1357_9BD3;
        endcase
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare, advance model.
    task automatic cycle();
        bit           rv;
        instruction_t rdat;
        bit           exp_req, ld, disc;
        logic [31:0]  cur_pc;
        @(negedge clk);
        rv   = 1'b0;
        rdat = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rv       = 1'b1;
                rdat     = mem_word(mem_addr);
                mem_busy = 1'b0;
            end
        end
        if (!rst_n_v) begin
            rv       = 1'b0;
            mem_busy = 1'b0;
        end
        rst_i         = rst_n_v;
        stall_i       = st_v;
        redirect_i    = rd_v;
        redirect_pc_i = rpc_v;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdat;
        #1;
        if (!rst_n_v) begin
            if (prev_rst_low) begin
                chk("rst valid", valid_o, 1'b0);
                chk("rst pc_o", pc_o, 32'h0);
                chk("rst instr", instruction_o, 32'h0000_0013);
                chk("rst addr", imem_addr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
                chk("rst perf", {perf_fetched_o, perf_squashed_o | perf_stall_cycles_o}, 64'h0);
`endif
            end
            prev_rst_low = 1'b1;
            m_pc = 32'h0; m_infl = 1'b0; m_stale = 1'b0; m_sv = 1'b0;
            m_pf = 0; m_ps = 0; m_pst = 0;
            return;
        end
        prev_rst_low = 1'b0;
        cur_pc  = m_pc;
        exp_req = !m_infl && !rd_v && (!m_sv || !st_v);
        chk("req", imem_req_o, exp_req);
        chk("addr", imem_addr_o, cur_pc);
        chk("valid", valid_o, m_sv);
        if (m_sv) begin
            chk("pc_o", pc_o, m_spc);
            chk("instr", instruction_o, m_sins);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf fetched", perf_fetched_o, m_pf);
        chk("perf squashed", perf_squashed_o, m_ps);
        chk("perf stall", perf_stall_cycles_o, m_pst);
`endif
        // what this edge does, in transaction terms
        ld   = rv && m_infl && !m_stale && !rd_v;
        disc = rv && m_infl && !ld;
        m_pf  += ld;
        m_ps  += disc + (rd_v && m_sv);
        m_pst += (m_sv && st_v);
        if (m_sv && !st_v) m_sv = 1'b0;
        if (ld) begin
            m_sv = 1'b1; m_spc = m_infl_pc; m_sins = rdat; m_pc = m_infl_pc + 32'd4;
        end
        if (rv) m_infl = 1'b0;
        if (rd_v) begin
            if (m_infl) m_stale = 1'b1;
            m_pc = {rpc_v[31:2], 2'b00};
            m_sv = 1'b0;
        end
        if (exp_req) begin
            m_infl = 1'b1; m_stale = 1'b0; m_infl_pc = cur_pc;
            mem_busy = 1'b1; mem_cnt = lat_v; mem_addr = cur_pc;
        end
    endtask

    initial begin
        rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;

        // reset, then 1-cycle memory: two fetches at 1 instr / 2 cycles
        rst_n_v = 1'b0; repeat (3) cycle();
        rst_n_v = 1'b1; lat_v = 1;
        cycle(); chk("t1 req0", imem_req_o, 1'b1); chk("t1 addr0", imem_addr_o, 32'h0);
        cycle(); chk("t1 wait req", imem_req_o, 1'b0);
        cycle(); chk("t1 v0", valid_o, 1'b1); chk("t1 pc0", pc_o, 32'h0);
                 chk("t1 ins0", instruction_o, 32'h0050_0093); chk("t1 addr4", imem_addr_o, 32'h4);
        cycle(); chk("t1 gap", valid_o, 1'b0);
        cycle(); chk("t1 pc4", pc_o, 32'h4); chk("t1 ins4", instruction_o, 32'h0010_8113);
                 chk("t1 addr8", imem_addr_o, 32'h8);
        cycle();

        // held stall on a valid slot
        st_v = 1'b1;
        repeat (3) begin
            cycle(); chk("t2 hold v", valid_o, 1'b1); chk("t2 hold pc", pc_o, 32'h8);
            chk("t2 no req", imem_req_o, 1'b0);
        end
        st_v = 1'b0; lat_v = 3;
        cycle(); chk("t2 req12", imem_req_o, 1'b1); chk("t2 addr12", imem_addr_o, 32'hC);

        // reset mid-request, then redirect while waiting on 3-cycle memory
        rst_n_v = 1'b0; repeat (2) cycle();
        rst_n_v = 1'b1;
        cycle(); chk("t3 addr0", imem_addr_o, 32'h0);
        rd_v = 1'b1; rpc_v = 32'h100; cycle();
        rd_v = 1'b0; cycle(); chk("t3 drain req", imem_req_o, 1'b0);
        cycle(); chk("t3 late drop", valid_o, 1'b0);
        lat_v = 1;
        cycle(); chk("t3 req", imem_req_o, 1'b1); chk("t3 addr100", imem_addr_o, 32'h100);
        cycle(); cycle(); chk("t3 pc100", pc_o, 32'h100);
        cycle(); st_v = 1'b1;
        cycle(); chk("t3 pc104", pc_o, 32'h104);
`ifdef FETCH_PERF_CNT_EN
        chk("t6 fetched", perf_fetched_o, 32'd2); chk("t6 squashed", perf_squashed_o, 32'd1);
`endif

        // redirect under stall flushes valid slot; then redirect with rvalid
        rd_v = 1'b1; rpc_v = 32'h203; cycle(); chk("t4 pre flush", valid_o, 1'b1);
        rd_v = 1'b0; cycle(); chk("t4 flushed", valid_o, 1'b0); chk("t4 addr200", imem_addr_o, 32'h200);
        chk("t4 req", imem_req_o, 1'b1);
        rd_v = 1'b1; rpc_v = 32'h300; cycle(); chk("t4 rv+rd req", imem_req_o, 1'b0);
        rd_v = 1'b0; cycle(); chk("t4 drop", valid_o, 1'b0); chk("t4 addr300", imem_addr_o, 32'h300);

        // wrap past the top of the address space
        st_v = 1'b0; rd_v = 1'b1; rpc_v = 32'hFFFF_FFFC; cycle();
        rd_v = 1'b0; cycle(); chk("t5 addr top", imem_addr_o, 32'hFFFF_FFFC);
        cycle(); cycle(); chk("t5 pc top", pc_o, 32'hFFFF_FFFC); chk("t5 wrap", imem_addr_o, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (rst_n_v == 1'b0) rst_n_v = ($urandom_range(0, 1) == 0);
            else rst_n_v = ($urandom_range(0, 499) != 0);
            st_v  = ($urandom_range(0, 9) < 3);
            rd_v  = ($urandom_range(0, 19) == 0);
            rpc_v = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            lat_v = $urandom_range(1, 4);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
